if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction fetch controller for the MUSA IF stage. It sits between the program counter register and the IF/ID pipeline boundary. It reads the current PC value, runs a req/ack transaction with instruction memory, and computes the next PC (sequential or redirected), driving the PC's write-enable and input. It owns the IF/ID pipeline register, including stall, skid-hold and flush behaviour.

Parameters:
ADDR_W, 32, width of PC and instruction-memory address
DATA_W, 32, instruction word width
NOP_INSTR, 32'h0000_0000, instruction value loaded into IF/ID on reset or flush

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
pc_value  input  ADDR_W  current PC register output
pc_next  output  ADDR_W  value to load into the PC
pc_write  output  1  PC load enable, one-cycle pulse
imem_req  output  1  instruction memory request
imem_addr  output  ADDR_W  fetch address, equal to latched PC while imem_req=1
imem_ack  input  1  memory returns imem_rdata this cycle; may be asserted in the same cycle as imem_req
imem_rdata  input  DATA_W  fetched instruction, valid when imem_ack=1
stall_id  input  1  ID stage cannot accept; hold IF/ID
redirect  input  1  taken branch/jump from EX; one-cycle pulse
redirect_target  input  ADDR_W  new PC, valid with redirect
ifid_instr  output  DATA_W  IF/ID instruction
ifid_pc4  output  ADDR_W  IF/ID PC+4
ifid_valid  output  1  IF/ID contents are a real instruction

Behaviour:
- Reset (reset=0, async) values: state=IDLE, imem_req=0, pc_write=0, ifid_instr=NOP_INSTR, ifid_pc4=0, ifid_valid=0, skid buffer empty, redirect-pending flag clear.
- States:
  - IDLE: entered at reset; moves to FETCH on the first edge after reset deasserts.
  - FETCH: imem_req=1, imem_addr=pc_value latched on entry; remains here until imem_ack.
  - HOLD: fetched word is parked in the skid buffer while ID is stalled; imem_req=0.
- Memory handshake: once imem_req rises, imem_req and imem_addr stay stable until the cycle with imem_ack=1. imem_req is never withdrawn early, including on redirect.
- FETCH with imem_ack=1, no redirect, no pending redirect:
  - If stall_id=0: load IF/ID {imem_rdata, pc+4, valid=1}; pc_write=1, pc_next=pc+4; stay in FETCH (new address next cycle).
  - If stall_id=1: store {imem_rdata, pc+4} in the skid buffer; pc_write=1, pc_next=pc+4; go to HOLD; IF/ID unchanged.
- HOLD: when stall_id=0, move the skid buffer into IF/ID with valid=1, then go to FETCH. While stall_id=1, everything holds.
- With zero-wait memory (ack in the request cycle), throughput is 1 instruction per cycle. Each wait cycle adds 1 cycle.
- Redirect handling; redirect has priority over stall and over sequential fetch:
  - In IDLE, HOLD, or FETCH with ack in the same cycle: pc_write=1, pc_next=redirect_target; fetched/skid data is discarded; go to FETCH.
  - In FETCH without ack: latch redirect_target and set the pending flag; keep the request. On the eventual ack, discard rdata, pc_write=1, pc_next=pending target, clear the flag.
  - A new redirect while the flag is set overwrites the latched target.
  - Every redirect clears ifid_valid and loads ifid_instr=NOP_INSTR on that edge, regardless of stall_id.
- pc_write is combinational from state and inputs and is high for exactly one cycle per accepted fetch or redirect. It is never high in IDLE unless redirect=1.
- Arithmetic: pc+4 is unsigned modulo 2^ADDR_W; 32'hFFFF_FFFC + 4 = 0. Address alignment is not checked.
- When stall_id=1 and no redirect, IF/ID holds its value, including ifid_valid=0.

Decomposition:
- Shared package musa_if_pkg: fetch state encoding (IDLE, FETCH, HOLD), NOP_INSTR default, INSTR_BYTES=4 constant.
- One sub-module, ifid_register: IF/ID pipeline register with load/stall/flush inputs and NOP reset. The FSM, skid buffer and next-PC logic stay in if_fetch_unit.

Test Plan:
- Reset then zero-wait memory (ack=req), pc_value stepping 0,4,8 -> imem_addr 0,4,8 on consecutive cycles; ifid_pc4 4,8,12; ifid_valid=1 from the 2nd post-reset edge; pc_write high every FETCH cycle.
- Ack delayed 3 cycles at pc=0x10 -> imem_req held 4 cycles with addr 0x10; a single pc_write pulse with pc_next=0x14.
- stall_id=1 for 2 cycles during ack of 0x20 -> HOLD, IF/ID unchanged; on release ifid_instr=word@0x20, ifid_pc4=0x24; no duplicate or lost instruction.
- redirect=1, target=0x100, while a request for 0x40 is pending -> req stays up until ack; rdata dropped; pc_write with pc_next=0x100; ifid_valid=0; next fetch address 0x100.
- pc_value=0xFFFF_FFFC fetched -> pc_next=0, ifid_pc4=0.
- reset asserted mid-wait with imem_req=1 -> all outputs return to their reset values immediately (async); FETCH resumes one edge after release.

Source files
------------

// File: rtl/musa_if_pkg.sv
// musa_if_pkg: shared fetch-stage constants and FSM state encoding.
package musa_if_pkg;
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t S_IDLE = 2'd0;
  localparam fetch_state_t S_FETCH = 2'd1;
  localparam fetch_state_t S_HOLD = 2'd2;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/ifid_register.sv
// ifid_register: IF/ID pipeline register with load, stall hold, flush and NOP reset.
module ifid_register
  import musa_if_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [ADDR_W-1:0] pc4_in,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc4,
  output logic              valid
);
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic              valid_q, valid_d;
  // Without a load or stall, ID consumed the entry, so a bubble is left behind.
  always_comb begin
    instr_d = flush ? NOP_INSTR : load ? instr_in : instr_q;
    pc4_d   = (load && !flush) ? pc4_in : pc4_q;
    valid_d = flush ? 1'b0 : load ? 1'b1 : stall ? valid_q : 1'b0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end
  assign instr = instr_q;
  assign pc4   = pc4_q;
  assign valid = valid_q;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF-stage controller running the imem handshake, next-PC selection and IF/ID skid/flush.
module if_fetch_unit
  import musa_if_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_value,
  output logic [ADDR_W-1:0] pc_next,
  output logic              pc_write,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              stall_id,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc4,
  output logic              ifid_valid
);
  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, tgt_q, tgt_d, skid_pc4_q, skid_pc4_d, pc4;
  logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
  logic              pend_q, pend_d, ack_f, accept, ifid_load;
  always_comb begin
    pc4       = addr_q + ADDR_W'(INSTR_BYTES);
    ack_f     = (state_q == S_FETCH) && imem_ack;
    accept    = ack_f && !redirect && !pend_q;
    pc_write  = ack_f || (redirect && state_q != S_FETCH);
    pc_next   = redirect ? redirect_target : pend_q ? tgt_q : pc4;
    // A redirect during an outstanding request is deferred until the ack.
    pend_d    = (state_q == S_FETCH) && !imem_ack && (pend_q || redirect);
    tgt_d     = redirect ? redirect_target : tgt_q;
    addr_d    = pc_write ? pc_next : (state_q == S_IDLE) ? pc_value : addr_q;
    skid_instr_d = ack_f ? imem_rdata : skid_instr_q;
    skid_pc4_d   = ack_f ? pc4 : skid_pc4_q;
    state_d   = (state_q == S_IDLE) ? S_FETCH :
                (state_q == S_FETCH) ? ((accept && stall_id) ? S_HOLD : S_FETCH) :
                (redirect || !stall_id) ? S_FETCH : S_HOLD;
    ifid_load = !redirect && !stall_id && (accept || state_q == S_HOLD);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      tgt_q        <= '0;
      pend_q       <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      tgt_q        <= tgt_d;
      pend_q       <= pend_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end
  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = addr_q;
  ifid_register #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NOP_INSTR(NOP_INSTR)) u_ifid (
    .clk      (clk),
    .reset    (reset),
    .load     (ifid_load),
    .stall    (stall_id),
    .flush    (redirect),
    .instr_in (state_q == S_HOLD ? skid_instr_q : imem_rdata),
    .pc4_in   (state_q == S_HOLD ? skid_pc4_q : pc4),
    .instr    (ifid_instr),
    .pc4      (ifid_pc4),
    .valid    (ifid_valid)
  );
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed scenario tests for if_fetch_unit with a bench-side PC register model.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_value = '0;
  logic [31:0] pc_next;
  logic        pc_write;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall_id = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  int checks = 0;
  int errors = 0;

  if_fetch_unit dut (
    .clk(clk), .reset(reset), .pc_value(pc_value), .pc_next(pc_next), .pc_write(pc_write),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall_id(stall_id), .redirect(redirect), .redirect_target(redirect_target),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic a, input logic [31:0] d, input logic s, input logic r, input logic [31:0] t);
    @(negedge clk);
    imem_ack = a; imem_rdata = d; stall_id = s; redirect = r; redirect_target = t;
    #1;
  endtask

  task automatic tick();
    logic w;
    logic [31:0] n;
    w = pc_write; n = pc_next;
    @(posedge clk);
    #1;
    if (w) pc_value = n;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", imem_req); end
    checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL rst_pcw got %0b exp 0", pc_write); end
    checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", ifid_instr); end
    checks++; if (ifid_pc4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h exp 0", ifid_pc4); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", ifid_valid); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got %0b exp 0", imem_req); end
    checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL idle_pcw got %0b exp 0", pc_write); end
    tick();
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL edge1_valid got %0b exp 0", ifid_valid); end
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = 32'(4 * i);
      drive(1'b1, 32'hA000_0000 | a, 1'b0, 1'b0, 32'h0);
      checks++; if (imem_req !== 1'b1 || imem_addr !== a) begin errors++; $display("FAIL zw_addr got req=%0b addr=%h exp req=1 addr=%h", imem_req, imem_addr, a); end
      checks++; if (pc_write !== 1'b1 || pc_next !== a + 4) begin errors++; $display("FAIL zw_pcw got %0b/%h exp 1/%h", pc_write, pc_next, a + 4); end
      tick();
      checks++; if (ifid_valid !== 1'b1 || ifid_pc4 !== a + 4 || ifid_instr !== (32'hA000_0000 | a)) begin
        errors++; $display("FAIL zw_ifid got %0b/%h/%h exp 1/%h/%h", ifid_valid, ifid_pc4, ifid_instr, a + 4, 32'hA000_0000 | a);
      end
    end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL wait_req got %0b/%h exp 1/00000010", imem_req, imem_addr); end
      checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL wait_pcw got %0b exp 0", pc_write); end
      tick();
    end
    drive(1'b1, 32'hA000_0010, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL wait_ackreq got %0b/%h exp 1/00000010", imem_req, imem_addr); end
    checks++; if (pc_write !== 1'b1 || pc_next !== 32'h14) begin errors++; $display("FAIL wait_pcw_ack got %0b/%h exp 1/00000014", pc_write, pc_next); end
    tick();
    checks++; if (ifid_instr !== 32'hA000_0010 || ifid_pc4 !== 32'h14 || ifid_valid !== 1'b1) begin
      errors++; $display("FAIL wait_ifid got %h/%h/%0b exp a0000010/00000014/1", ifid_instr, ifid_pc4, ifid_valid);
    end
  endtask

  task automatic test_stall_hold();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a;
      a = 32'h14 + 32'(4 * i);
      drive(1'b1, 32'hA000_0000 | a, 1'b0, 1'b0, 32'h0);
      checks++; if (imem_addr !== a) begin errors++; $display("FAIL st_pre_addr got %h exp %h", imem_addr, a); end
      tick();
    end
    drive(1'b1, 32'hA000_0020, 1'b1, 1'b0, 32'h0);
    checks++; if (pc_write !== 1'b1 || pc_next !== 32'h24) begin errors++; $display("FAIL st_pcw got %0b/%h exp 1/00000024", pc_write, pc_next); end
    tick();
    checks++; if (ifid_instr !== 32'hA000_001C || ifid_pc4 !== 32'h20 || ifid_valid !== 1'b1) begin
      errors++; $display("FAIL st_hold1 got %h/%h/%0b exp a000001c/00000020/1", ifid_instr, ifid_pc4, ifid_valid);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checks++; if (imem_req !== 1'b0 || pc_write !== 1'b0) begin errors++; $display("FAIL st_hold_req got %0b/%0b exp 0/0", imem_req, pc_write); end
    tick();
    checks++; if (ifid_instr !== 32'hA000_001C || ifid_pc4 !== 32'h20) begin errors++; $display("FAIL st_hold2 got %h/%h exp a000001c/00000020", ifid_instr, ifid_pc4); end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_req !== 1'b0 || pc_write !== 1'b0) begin errors++; $display("FAIL st_rel_req got %0b/%0b exp 0/0", imem_req, pc_write); end
    tick();
    checks++; if (ifid_instr !== 32'hA000_0020 || ifid_pc4 !== 32'h24 || ifid_valid !== 1'b1) begin
      errors++; $display("FAIL st_release got %h/%h/%0b exp a0000020/00000024/1", ifid_instr, ifid_pc4, ifid_valid);
    end
    drive(1'b1, 32'hA000_0024, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h24) begin errors++; $display("FAIL st_next_addr got %0b/%h exp 1/00000024", imem_req, imem_addr); end
    tick();
    checks++; if (ifid_instr !== 32'hA000_0024 || ifid_pc4 !== 32'h28) begin errors++; $display("FAIL st_next_ifid got %h/%h exp a0000024/00000028", ifid_instr, ifid_pc4); end
  endtask

  task automatic test_redirect_pending();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'hA000_0000, 1'b0, 1'b0, 32'h0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || pc_write !== 1'b0) begin
      errors++; $display("FAIL rd_req got %0b/%h/%0b exp 1/00000040/0", imem_req, imem_addr, pc_write);
    end
    tick();
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin errors++; $display("FAIL rd_flush got %0b/%h exp 0/00000000", ifid_valid, ifid_instr); end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL rd_hold got %0b/%h exp 1/00000040", imem_req, imem_addr); end
    tick();
    drive(1'b1, 32'hBAD0_0040, 1'b0, 1'b0, 32'h0);
    checks++; if (pc_write !== 1'b1 || pc_next !== 32'h100) begin errors++; $display("FAIL rd_pcw got %0b/%h exp 1/00000100", pc_write, pc_next); end
    tick();
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rd_drop got %0b exp 0", ifid_valid); end
    drive(1'b1, 32'hA000_0100, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || pc_next !== 32'h104) begin
      errors++; $display("FAIL rd_newaddr got %0b/%h/%h exp 1/00000100/00000104", imem_req, imem_addr, pc_next);
    end
    tick();
    checks++; if (ifid_instr !== 32'hA000_0100 || ifid_pc4 !== 32'h104 || ifid_valid !== 1'b1) begin
      errors++; $display("FAIL rd_ifid got %h/%h/%0b exp a0000100/00000104/1", ifid_instr, ifid_pc4, ifid_valid);
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 32'hBAD0_0104, 1'b1, 1'b1, 32'hFFFF_FFFC);
    checks++; if (pc_write !== 1'b1 || pc_next !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_redir got %0b/%h exp 1/fffffffc", pc_write, pc_next); end
    tick();
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL wr_flush got %0b exp 0", ifid_valid); end
    drive(1'b1, 32'hA0FF_FFFC, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_addr !== 32'hFFFF_FFFC || pc_next !== 32'h0 || pc_write !== 1'b1) begin
      errors++; $display("FAIL wr_pcnext got %h/%h/%0b exp fffffffc/00000000/1", imem_addr, pc_next, pc_write);
    end
    tick();
    checks++; if (ifid_pc4 !== 32'h0 || ifid_instr !== 32'hA0FF_FFFC || ifid_valid !== 1'b1) begin
      errors++; $display("FAIL wr_ifid got %h/%h/%0b exp 00000000/a0fffffc/1", ifid_pc4, ifid_instr, ifid_valid);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL ar_pre got %0b/%h exp 1/00000000", imem_req, imem_addr); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || pc_write !== 1'b0) begin errors++; $display("FAIL ar_req got %0b/%0b exp 0/0", imem_req, pc_write); end
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0) begin
      errors++; $display("FAIL ar_ifid got %0b/%h/%h exp 0/00000000/00000000", ifid_valid, ifid_instr, ifid_pc4);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ar_idle got %0b exp 0", imem_req); end
    tick();
    drive(1'b1, 32'hA000_0000, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || pc_next !== 32'h4) begin
      errors++; $display("FAIL ar_resume got %0b/%h/%h exp 1/00000000/00000004", imem_req, imem_addr, pc_next);
    end
    tick();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'h4) begin errors++; $display("FAIL ar_ifid2 got %0b/%h exp 1/00000004", ifid_valid, ifid_pc4); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall_hold();
    test_redirect_pending();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
